// File: rtl/stopwatch_err_display_if.sv
// Bundle between the stopwatch display block and its neighbours.
//   err1, err2   : error detector levels (into the display block)
//   digits[15:0] : BCD MM:SS time (into the display block)
//   hex3..hex0   : active-low 7-segment patterns, bit 6 = g .. bit 0 = a
//   err_active   : high while an error flash sequence is in progress
//   state        : debug view of the flash FSM state
// The block has no handshake. Inputs are sampled on every rising clk edge,
// and outputs are registered and valid on every cycle.
// The master modport is the upstream/board side. The slave modport is the
// display block itself.
interface stopwatch_err_display_if;
    logic        err1;
    logic        err2;
    logic [15:0] digits;
    logic [6:0]  hex3;
    logic [6:0]  hex2;
    logic [6:0]  hex1;
    logic [6:0]  hex0;
    logic        err_active;
    logic [2:0]  state;

    modport master (
        output err1, err2, digits,
        input  hex3, hex2, hex1, hex0, err_active, state
    );

    modport slave (
        input  err1, err2, digits,
        output hex3, hex2, hex1, hex0, err_active, state
    );
endinterface

// File: rtl/stopwatch_err_display.sv
// Stopwatch 4-digit 7-segment driver.
// Normally shows MM:SS from the BCD counter. A rising edge on err1 or err2
// replaces the time with a flashing "E1" or "E2" code. The code flashes
// ON/OFF twice, with each phase lasting BLINK_CYCLES clocks, and then the
// time display returns.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of stopwatch_err_display_if
//           (err1/err2/digits in; hex3..hex0, err_active and debug state out)
module stopwatch_err_display #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    stopwatch_err_display_if.slave  bus
);
    localparam logic [2:0] NORMAL = 3'd0;
    localparam logic [2:0] ON1    = 3'd1;
    localparam logic [2:0] OFF1   = 3'd2;
    localparam logic [2:0] ON2    = 3'd3;
    localparam logic [2:0] OFF2   = 3'd4;

    localparam logic [25:0] LAST = 26'(BLINK_CYCLES - 1);

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic        err1_q, err2_q;
    logic [15:0] digits_q;
    logic [2:0]  state, next_phase;
    logic [1:0]  code;
    logic [25:0] cnt;
    logic [6:0]  hex3_r, hex2_r, hex1_r, hex0_r;
    logic        err_active_r;
    logic        rise1, rise2;

    // Active-low g..a encoding. BCD values 10-15 display as blank.
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    endfunction

    // Only a 0->1 transition triggers. A held level never retriggers.
    assign rise1 = bus.err1 & ~err1_q;
    assign rise2 = bus.err2 & ~err2_q;

    always_comb begin
        next_phase = NORMAL;
        case (state)
            ON1:     next_phase = OFF1;
            OFF1:    next_phase = ON2;
            ON2:     next_phase = OFF2;
            default: next_phase = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err1_q       <= 1'b0;
            err2_q       <= 1'b0;
            digits_q     <= 16'h0000;
            state        <= NORMAL;
            code         <= 2'd1;
            cnt          <= 26'd0;
            hex3_r       <= SEG_BLANK;
            hex2_r       <= SEG_BLANK;
            hex1_r       <= SEG_BLANK;
            hex0_r       <= SEG_BLANK;
            err_active_r <= 1'b0;
        end else begin
            err1_q   <= bus.err1;
            err2_q   <= bus.err2;
            // The extra stage on the time path gives a 2-edge input-to-pin latency.
            digits_q <= bus.digits;

            // rise1 beats rise2. Any rise restarts the sequence, even mid-flash.
            if (rise1) begin
                state <= ON1;
                code  <= 2'd1;
                cnt   <= 26'd0;
            end else if (rise2) begin
                state <= ON1;
                code  <= 2'd2;
                cnt   <= 26'd0;
            end else if (state == NORMAL) begin
                cnt <= 26'd0;
            end else if (cnt == LAST) begin
                state <= next_phase;
                cnt   <= 26'd0;
            end else begin
                cnt <= cnt + 26'd1;
            end

            // The outputs follow the current state, one edge behind it.
            case (state)
                NORMAL: begin
                    hex3_r <= seg(digits_q[15:12]);
                    hex2_r <= seg(digits_q[11:8]);
                    hex1_r <= seg(digits_q[7:4]);
                    hex0_r <= seg(digits_q[3:0]);
                end
                ON1, ON2: begin
                    hex3_r <= SEG_BLANK;
                    hex2_r <= SEG_BLANK;
                    hex1_r <= SEG_E;
                    hex0_r <= seg({2'b00, code});
                end
                default: begin
                    hex3_r <= SEG_BLANK;
                    hex2_r <= SEG_BLANK;
                    hex1_r <= SEG_BLANK;
                    hex0_r <= SEG_BLANK;
                end
            endcase
            err_active_r <= (state != NORMAL);
        end
    end

    assign bus.hex3       = hex3_r;
    assign bus.hex2       = hex2_r;
    assign bus.hex1       = hex1_r;
    assign bus.hex0       = hex0_r;
    assign bus.err_active = err_active_r;
    assign bus.state      = state;
endmodule
